exmem_skid_stage: RTL and testbench

// Parametrised EX->MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer,
// and synchronous flush. It replaces the plain always-load EX/MEM register, so MEM back-pressure
// no longer needs a global stall. It answers rs1/rs2 forwarding queries from both held entries.

---
 rtl/riscv_pipe_pkg.sv | 48 ++++
 rtl/exmem_fwd_match.sv | 47 ++++
 rtl/exmem_skid_stage.sv | 176 +++++++++++++++++
 tb/tb_exmem_skid_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the EX->MEM pipeline stage: memory access size, per-entry
// control bits, payload layout and the occupancy state of the skid stage.
package riscv_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      wb_en;
    logic      read_en;
    logic      write_en;
    mem_size_e size;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [XLEN_DEF-1:0] store_data;
    logic [RAW_DEF-1:0]  rd;
    exmem_ctrl_t         ctrl;
  } exmem_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } exmem_occ_e;

  // A write to x0 is architecturally a no-op; a load/store collision keeps the load.
  function automatic exmem_ctrl_t sanitize_ctrl(input logic      rd_nonzero,
                                                input logic      wb_en,
                                                input logic      read_en,
                                                input logic      write_en,
                                                input logic [1:0] size);
    exmem_ctrl_t c;
    c.wb_en    = wb_en & rd_nonzero;
    c.read_en  = read_en;
    c.write_en = write_en & ~read_en;
    c.size     = mem_size_e'(size);
    return c;
  endfunction

endpackage

// File: rtl/exmem_fwd_match.sv
// Forwarding lookup for one source register across the two held entries;
// the younger entry wins when both carry a matching destination.
module exmem_fwd_match
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic [RAW-1:0]  rs_i,
  input  logic            young_valid_i,
  input  logic            young_wb_en_i,
  input  logic [RAW-1:0]  young_rd_i,
  input  logic [XLEN-1:0] young_result_i,
  input  logic            young_read_en_i,
  input  logic            old_valid_i,
  input  logic            old_wb_en_i,
  input  logic [RAW-1:0]  old_rd_i,
  input  logic [XLEN-1:0] old_result_i,
  input  logic            old_read_en_i,
  output logic            hit_o,
  output logic [XLEN-1:0] data_o,
  output logic            is_load_o
);

  logic young_match;
  logic old_match;

  assign young_match = young_valid_i & young_wb_en_i & (young_rd_i == rs_i) & (rs_i != '0);
  assign old_match   = old_valid_i & old_wb_en_i & (old_rd_i == rs_i) & (rs_i != '0);

  // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
  always_comb begin
    hit_o     = 1'b0;
    data_o    = '0;
    is_load_o = 1'b0;
    if (young_match) begin
      hit_o     = 1'b1;
      data_o    = young_result_i;
      is_load_o = young_read_en_i;
    end else if (old_match) begin
      hit_o     = 1'b1;
      data_o    = old_result_i;
      is_load_o = old_read_en_i;
    end
  end

endmodule

// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional second (skid)
// entry, synchronous flush and rs1/rs2 forwarding from every held entry.
module exmem_skid_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [RAW-1:0]  rd_i,
  input  logic            wb_en_i,
  input  logic            read_en_i,
  input  logic            write_en_i,
  input  logic [1:0]      size_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [RAW-1:0]  rd_o,
  output logic            wb_en_o,
  output logic            read_en_o,
  output logic            write_en_o,
  output logic [1:0]      size_o,
  input  logic [RAW-1:0]  fwd_rs1_i,
  input  logic [RAW-1:0]  fwd_rs2_i,
  output logic            fwd_rs1_hit_o,
  output logic            fwd_rs2_hit_o,
  output logic [XLEN-1:0] fwd_rs1_data_o,
  output logic [XLEN-1:0] fwd_rs2_data_o,
  output logic            fwd_load_hazard_o
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RAW-1:0]  rd;
    exmem_ctrl_t     ctrl;
  } entry_t;

  exmem_occ_e occ_q, occ_d;
  entry_t     head_q, head_d, skid_q, cap;
  logic       head_valid, skid_valid;
  logic       in_fire, out_fire, skid_load;
  logic       rs1_load, rs2_load;

  assign head_valid = (occ_q != OCC_EMPTY);
  assign skid_valid = (SKID != 0) && (occ_q == OCC_TWO);
  assign in_ready_o = (SKID != 0) ? !skid_valid : (!head_valid || out_ready_i);
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = head_valid & out_ready_i;

  always_comb begin
    cap.result     = result_i;
    cap.store_data = store_data_i;
    cap.rd         = rd_i;
    cap.ctrl       = sanitize_ctrl(rd_i != '0, wb_en_i, read_en_i, write_en_i, size_i);
  end

  always_comb begin
    occ_d     = occ_q;
    head_d    = head_q;
    skid_load = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          occ_d  = OCC_ONE;
          head_d = cap;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          head_d = cap;
        end else if (in_fire) begin
          occ_d     = OCC_TWO;
          skid_load = 1'b1;
        end else if (out_fire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          occ_d  = OCC_ONE;
          head_d = skid_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // A flushed beat must not disturb the held data fields either.
    if (flush_i) begin
      occ_d     = OCC_EMPTY;
      head_d    = head_q;
      skid_load = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, so all data outputs read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
    end
  end

  if (SKID != 0) begin : g_skid
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        skid_q <= '0;
      end else if (skid_load) begin
        skid_q <= cap;
      end
    end
  end else begin : g_no_skid
    assign skid_q = '0;
  end

  assign out_valid_o  = head_valid;
  assign result_o     = head_q.result;
  assign store_data_o = head_q.store_data;
  assign rd_o         = head_q.rd;
  assign size_o       = head_q.ctrl.size;
  assign wb_en_o      = head_valid & head_q.ctrl.wb_en;
  assign read_en_o    = head_valid & head_q.ctrl.read_en;
  assign write_en_o   = head_valid & head_q.ctrl.write_en;

  exmem_fwd_match #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
    .rs_i            (fwd_rs1_i),
    .young_valid_i   (skid_valid),
    .young_wb_en_i   (skid_q.ctrl.wb_en),
    .young_rd_i      (skid_q.rd),
    .young_result_i  (skid_q.result),
    .young_read_en_i (skid_q.ctrl.read_en),
    .old_valid_i     (head_valid),
    .old_wb_en_i     (head_q.ctrl.wb_en),
    .old_rd_i        (head_q.rd),
    .old_result_i    (head_q.result),
    .old_read_en_i   (head_q.ctrl.read_en),
    .hit_o           (fwd_rs1_hit_o),
    .data_o          (fwd_rs1_data_o),
    .is_load_o       (rs1_load)
  );

  exmem_fwd_match #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
    .rs_i            (fwd_rs2_i),
    .young_valid_i   (skid_valid),
    .young_wb_en_i   (skid_q.ctrl.wb_en),
    .young_rd_i      (skid_q.rd),
    .young_result_i  (skid_q.result),
    .young_read_en_i (skid_q.ctrl.read_en),
    .old_valid_i     (head_valid),
    .old_wb_en_i     (head_q.ctrl.wb_en),
    .old_rd_i        (head_q.rd),
    .old_result_i    (head_q.result),
    .old_read_en_i   (head_q.ctrl.read_en),
    .hit_o           (fwd_rs2_hit_o),
    .data_o          (fwd_rs2_data_o),
    .is_load_o       (rs2_load)
  );

  assign fwd_load_hazard_o = rs1_load | rs2_load;

  // A captured op that both loads and stores points at a decoder bug upstream.
  a_no_load_store : assert property (@(posedge clk) disable iff (!rst_n)
                                     !(in_fire && read_en_i && write_en_i));

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Self-checking bench for exmem_skid_stage: directed scenarios plus a random
// stream compared against a queue-based model of the held entries.
module tb_exmem_skid_stage;
  import riscv_pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [XLEN-1:0] result_i = '0;
  logic [XLEN-1:0] store_data_i = '0;
  logic [RAW-1:0]  rd_i = '0;
  logic            wb_en_i = 1'b0;
  logic            read_en_i = 1'b0;
  logic            write_en_i = 1'b0;
  logic [1:0]      size_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [XLEN-1:0] result_o, store_data_o;
  logic [RAW-1:0]  rd_o;
  logic            wb_en_o, read_en_o, write_en_o;
  logic [1:0]      size_o;
  logic [RAW-1:0]  fwd_rs1_i = '0;
  logic [RAW-1:0]  fwd_rs2_i = '0;
  logic            fwd_rs1_hit_o, fwd_rs2_hit_o;
  logic [XLEN-1:0] fwd_rs1_data_o, fwd_rs2_data_o;
  logic            fwd_load_hazard_o;

  always #5 clk = ~clk;

  exmem_skid_stage #(.XLEN(XLEN), .RAW(RAW), .SKID(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .result_i          (result_i),
    .store_data_i      (store_data_i),
    .rd_i              (rd_i),
    .wb_en_i           (wb_en_i),
    .read_en_i         (read_en_i),
    .write_en_i        (write_en_i),
    .size_i            (size_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .result_o          (result_o),
    .store_data_o      (store_data_o),
    .rd_o              (rd_o),
    .wb_en_o           (wb_en_o),
    .read_en_o         (read_en_o),
    .write_en_o        (write_en_o),
    .size_o            (size_o),
    .fwd_rs1_i         (fwd_rs1_i),
    .fwd_rs2_i         (fwd_rs2_i),
    .fwd_rs1_hit_o     (fwd_rs1_hit_o),
    .fwd_rs2_hit_o     (fwd_rs2_hit_o),
    .fwd_rs1_data_o    (fwd_rs1_data_o),
    .fwd_rs2_data_o    (fwd_rs2_data_o),
    .fwd_load_hazard_o (fwd_load_hazard_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: ordered list of ops held by the stage (front = oldest = head).
  exmem_payload_t held[$];
  exmem_payload_t last_head = '0;
  exmem_payload_t seen[$];

  function automatic exmem_payload_t sanitize(input exmem_payload_t o);
    exmem_payload_t r = o;
    if (o.rd == '0) r.ctrl.wb_en = 1'b0;
    if (o.ctrl.read_en) r.ctrl.write_en = 1'b0;
    return r;
  endfunction

  function automatic exmem_payload_t rand_op();
    exmem_payload_t r;
    int kind;
    r.result        = $urandom;
    r.store_data    = $urandom;
    r.rd            = RAW'($urandom_range(0, 7));
    r.ctrl.wb_en    = 1'($urandom_range(0, 1));
    kind            = $urandom_range(0, 2);
    r.ctrl.read_en  = (kind == 1);
    r.ctrl.write_en = (kind == 2);
    r.ctrl.size     = mem_size_e'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic exmem_payload_t mk_op(input logic [31:0] res, input logic [4:0] rd,
                                          input logic wb, input logic ld);
    exmem_payload_t r = '0;
    r.result       = res;
    r.store_data   = ~res;
    r.rd           = rd;
    r.ctrl.wb_en   = wb;
    r.ctrl.read_en = ld;
    r.ctrl.size    = WORD;
    return r;
  endfunction

  // Youngest held entry that writes rs wins; x0 never matches.
  task automatic exp_fwd(input logic [RAW-1:0] rs, output logic hit,
                         output logic [XLEN-1:0] data, output logic ld);
    hit = 1'b0; data = '0; ld = 1'b0;
    if (rs != '0) begin
      for (int i = held.size() - 1; i >= 0; i--) begin
        if (held[i].ctrl.wb_en && held[i].rd == rs) begin
          hit = 1'b1; data = held[i].result; ld = held[i].ctrl.read_en;
          break;
        end
      end
    end
  endtask

  task automatic drive(input exmem_payload_t o, input logic v);
    in_valid_i   = v;
    result_i     = o.result;
    store_data_i = o.store_data;
    rd_i         = o.rd;
    wb_en_i      = o.ctrl.wb_en;
    read_en_i    = o.ctrl.read_en;
    write_en_i   = o.ctrl.write_en;
    size_i       = o.ctrl.size;
  endtask

  // One clock: records what MEM consumes, advances the model, returns at negedge.
  task automatic step();
    logic in_f, out_f;
    exmem_payload_t c, obs;
    in_f = in_valid_i && (held.size() < 2);
    out_f = (held.size() != 0) && out_ready_i;
    c.result = result_i; c.store_data = store_data_i; c.rd = rd_i;
    c.ctrl.wb_en = wb_en_i; c.ctrl.read_en = read_en_i; c.ctrl.write_en = write_en_i;
    c.ctrl.size = mem_size_e'(size_i);
    c = sanitize(c);
    if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
      obs = '0; obs.result = result_o; obs.store_data = store_data_o; obs.rd = rd_o;
      seen.push_back(obs);
    end
    @(posedge clk);
    if (!rst_n) begin
      held.delete(); last_head = '0;
    end else if (flush_i) begin
      held.delete();
    end else begin
      if (out_f) void'(held.pop_front());
      if (in_f) held.push_back(c);
    end
    if (held.size() != 0) last_head = held[0];
    @(negedge clk);
  endtask

  task automatic idle();
    drive('0, 1'b0);
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready_i = 1'b1; fwd_rs1_i = 5'd3; fwd_rs2_i = 5'd4;
    drive(mk_op(32'h1234, 5'd3, 1'b1, 1'b0), 1'b1);
    step(); step();
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    n_checks++; if ({result_o, store_data_o, rd_o, size_o} !== '0) begin n_errors++; $display("FAIL reset_data: got %h %h %h %h want 0", result_o, store_data_o, rd_o, size_o); end
    n_checks++; if ({wb_en_o, read_en_o, write_en_o, fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_load_hazard_o} !== '0) begin n_errors++; $display("FAIL reset_ctrl: got %b%b%b%b%b%b want 0", wb_en_o, read_en_o, write_en_o, fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_load_hazard_o); end
    rst_n = 1'b1; idle(); step();
  endtask

  task automatic test_stream();
    exmem_payload_t op;
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = rand_op(); op.rd = RAW'(i + 1);
      drive(op, 1'b1);
      n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready_o); end
      step();
      op = sanitize(op);
      n_checks++; if (out_valid_o !== 1'b1 || result_o !== op.result || rd_o !== op.rd || wb_en_o !== op.ctrl.wb_en)
        begin n_errors++; $display("FAIL stream_out[%0d]: got v=%b res=%h rd=%0d wb=%b want v=1 res=%h rd=%0d wb=%b", i, out_valid_o, result_o, rd_o, wb_en_o, op.result, op.rd, op.ctrl.wb_en); end
    end
    idle(); step();
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL stream_drain: got %b want 0", out_valid_o); end
  endtask

  task automatic test_stall();
    exmem_payload_t a, b, c;
    logic c_pending;
    a = mk_op(32'hA0A0_0001, 5'd1, 1'b1, 1'b0);
    b = mk_op(32'hB0B0_0002, 5'd2, 1'b1, 1'b0);
    c = mk_op(32'hC0C0_0003, 5'd3, 1'b1, 1'b0);
    seen.delete();
    out_ready_i = 1'b1; drive(a, 1'b1); step();
    out_ready_i = 1'b0; drive(b, 1'b1); step();
    n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready_c2: got %b want 0", in_ready_o); end
    drive(c, 1'b1); step();
    n_checks++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || result_o !== a.result)
      begin n_errors++; $display("FAIL stall_hold: got rdy=%b v=%b res=%h want rdy=0 v=1 res=%h", in_ready_o, out_valid_o, result_o, a.result); end
    step();
    out_ready_i = 1'b1; c_pending = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (c_pending && in_ready_o) begin step(); c_pending = 1'b0; idle(); end
      else step();
    end
    n_checks++; if (seen.size() != 3) begin n_errors++; $display("FAIL stall_count: got %0d want 3", seen.size()); end
    else begin
      n_checks++; if (seen[0].result !== a.result || seen[1].result !== b.result || seen[2].result !== c.result)
        begin n_errors++; $display("FAIL stall_order: got %h %h %h want %h %h %h", seen[0].result, seen[1].result, seen[2].result, a.result, b.result, c.result); end
    end
  endtask

  task automatic test_flush();
    exmem_payload_t a, b, d, e;
    a = mk_op(32'h0000_AAAA, 5'd6, 1'b1, 1'b0);
    b = mk_op(32'h0000_BBBB, 5'd7, 1'b1, 1'b0);
    d = mk_op(32'h0000_DDDD, 5'd8, 1'b1, 1'b0);
    e = mk_op(32'h0000_EEEE, 5'd9, 1'b1, 1'b0);
    seen.delete();
    out_ready_i = 1'b0; drive(a, 1'b1); step(); drive(b, 1'b1); step();
    drive(d, 1'b1); flush_i = 1'b1; step();
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      begin n_errors++; $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", out_valid_o, in_ready_o); end
    n_checks++; if (result_o !== a.result || wb_en_o !== 1'b0)
      begin n_errors++; $display("FAIL flush_hold: got res=%h wb=%b want res=%h wb=0", result_o, wb_en_o, a.result); end
    idle(); out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (seen.size() != 0 || out_valid_o !== 1'b0)
      begin n_errors++; $display("FAIL flush_no_replay: got %0d ops v=%b want 0 ops v=0", seen.size(), out_valid_o); end
    out_ready_i = 1'b0; drive(a, 1'b1); step();
    drive(e, 1'b1); flush_i = 1'b1; step();
    idle(); step();
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== a.result)
      begin n_errors++; $display("FAIL flush_drop_in: got v=%b rdy=%b res=%h want v=0 rdy=1 res=%h", out_valid_o, in_ready_o, result_o, a.result); end
  endtask

  task automatic test_sanitize();
    exmem_payload_t z;
    z = mk_op(32'hDEAD, 5'd0, 1'b1, 1'b0);
    out_ready_i = 1'b0; fwd_rs1_i = 5'd0; fwd_rs2_i = 5'd0;
    drive(z, 1'b1); step(); idle();
    n_checks++; if (out_valid_o !== 1'b1 || result_o !== 32'hDEAD || wb_en_o !== 1'b0)
      begin n_errors++; $display("FAIL sanitize_x0: got v=%b res=%h wb=%b want v=1 res=dead wb=0", out_valid_o, result_o, wb_en_o); end
    n_checks++; if (fwd_rs1_hit_o !== 1'b0 || fwd_rs1_data_o !== '0)
      begin n_errors++; $display("FAIL sanitize_fwd_x0: got hit=%b data=%h want hit=0 data=0", fwd_rs1_hit_o, fwd_rs1_data_o); end
    flush_i = 1'b1; step(); flush_i = 1'b0;
  endtask

  task automatic test_fwd_priority();
    out_ready_i = 1'b0;
    drive(mk_op(32'h11, 5'd5, 1'b1, 1'b0), 1'b1); step();
    drive(mk_op(32'h22, 5'd5, 1'b1, 1'b1), 1'b1); step();
    idle(); fwd_rs1_i = 5'd5; fwd_rs2_i = 5'd7; #1;
    n_checks++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h22 || fwd_load_hazard_o !== 1'b1)
      begin n_errors++; $display("FAIL fwd_skid_wins: got hit=%b data=%h hz=%b want hit=1 data=22 hz=1", fwd_rs1_hit_o, fwd_rs1_data_o, fwd_load_hazard_o); end
    n_checks++; if (fwd_rs2_hit_o !== 1'b0 || fwd_rs2_data_o !== '0)
      begin n_errors++; $display("FAIL fwd_miss: got hit=%b data=%h want hit=0 data=0", fwd_rs2_hit_o, fwd_rs2_data_o); end
    fwd_rs1_i = 5'd0; fwd_rs2_i = 5'd5; #1;
    n_checks++; if (fwd_rs1_hit_o !== 1'b0 || fwd_rs2_hit_o !== 1'b1 || fwd_rs2_data_o !== 32'h22)
      begin n_errors++; $display("FAIL fwd_rs2: got h1=%b h2=%b data=%h want h1=0 h2=1 data=22", fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_rs2_data_o); end
    out_ready_i = 1'b1; step(); step();
    out_ready_i = 1'b0;
    drive(mk_op(32'h33, 5'd5, 1'b1, 1'b0), 1'b1); step(); idle(); #1;
    n_checks++; if (fwd_rs2_hit_o !== 1'b1 || fwd_rs2_data_o !== 32'h33 || fwd_load_hazard_o !== 1'b0)
      begin n_errors++; $display("FAIL fwd_head_only: got hit=%b data=%h hz=%b want hit=1 data=33 hz=0", fwd_rs2_hit_o, fwd_rs2_data_o, fwd_load_hazard_o); end
    flush_i = 1'b1; step(); flush_i = 1'b0;
  endtask

  task automatic test_reset_midstall();
    out_ready_i = 1'b0; fwd_rs1_i = 5'd1; fwd_rs2_i = 5'd2;
    drive(mk_op(32'h5555, 5'd1, 1'b1, 1'b1), 1'b1); step();
    drive(mk_op(32'h6666, 5'd2, 1'b1, 1'b0), 1'b1); step();
    n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL midstall_full: got rdy=%b want 0", in_ready_o); end
    rst_n = 1'b0; step(); rst_n = 1'b1; idle(); #1;
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || {result_o, store_data_o, rd_o, size_o} !== '0 ||
                    {wb_en_o, read_en_o, write_en_o, fwd_rs1_hit_o, fwd_rs2_hit_o, fwd_load_hazard_o} !== '0)
      begin n_errors++; $display("FAIL midstall_reset: got v=%b rdy=%b res=%h rd=%0d h1=%b h2=%b want all 0 rdy=1", out_valid_o, in_ready_o, result_o, rd_o, fwd_rs1_hit_o, fwd_rs2_hit_o); end
  endtask

  task automatic test_random();
    logic h1, h2, l1, l2, e_wb, e_rd, e_wr;
    logic [XLEN-1:0] d1, d2;
    int bad;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_fwd(fwd_rs1_i, h1, d1, l1);
      exp_fwd(fwd_rs2_i, h2, d2, l2);
      e_wb = (held.size() != 0) && last_head.ctrl.wb_en;
      e_rd = (held.size() != 0) && last_head.ctrl.read_en;
      e_wr = (held.size() != 0) && last_head.ctrl.write_en;
      bad = 0;
      if (out_valid_o !== (held.size() != 0)) bad++;
      if (in_ready_o !== (held.size() < 2)) bad++;
      if (result_o !== last_head.result || store_data_o !== last_head.store_data) bad++;
      if (rd_o !== last_head.rd || size_o !== last_head.ctrl.size) bad++;
      if (wb_en_o !== e_wb || read_en_o !== e_rd || write_en_o !== e_wr) bad++;
      if (fwd_rs1_hit_o !== h1 || fwd_rs1_data_o !== d1) bad++;
      if (fwd_rs2_hit_o !== h2 || fwd_rs2_data_o !== d2) bad++;
      if (fwd_load_hazard_o !== ((h1 && l1) || (h2 && l2))) bad++;
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL random[%0d]: got v=%b rdy=%b res=%h rd=%0d h1=%b d1=%h h2=%b d2=%h hz=%b want v=%b rdy=%b res=%h rd=%0d h1=%b d1=%h h2=%b d2=%h",
                 cyc, out_valid_o, in_ready_o, result_o, rd_o, fwd_rs1_hit_o, fwd_rs1_data_o, fwd_rs2_hit_o, fwd_rs2_data_o, fwd_load_hazard_o,
                 held.size() != 0, held.size() < 2, last_head.result, last_head.rd, h1, d1, h2, d2);
      end
      drive(rand_op(), ($urandom_range(0, 9) < 7));
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 19) == 0);
      fwd_rs1_i   = RAW'($urandom_range(0, 7));
      fwd_rs2_i   = RAW'($urandom_range(0, 7));
      step();
    end
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_sanitize();
    test_fwd_priority();
    test_reset_midstall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
